// File: rtl/wb_pkg.sv
// Shared types for the register-file write path: retire source, load funct3 codes, FSM states.
package wb_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned F3_W   = 3;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_PC4  = 2'd2,
      SRC_LOAD = 2'd3
   } wb_src_t;

   localparam logic [F3_W-1:0] F3_LB  = 3'd0;
   localparam logic [F3_W-1:0] F3_LH  = 3'd1;
   localparam logic [F3_W-1:0] F3_LW  = 3'd2;
   localparam logic [F3_W-1:0] F3_LBU = 3'd4;
   localparam logic [F3_W-1:0] F3_LHU = 3'd5;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// Selects the byte/half/word addressed by a load from an aligned memory word and extends it;
// flags misaligned accesses and undefined funct3 codes.
module load_extract
   import wb_pkg::*;
(
   input  logic [F3_W-1:0] funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data_c,
   output logic            bad_c
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane selection from the low address bits
   always_comb begin
      byte_v = word[7:0];
      case (addr_lo)
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         2'd3:    byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      half_v = addr_lo[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data_c = '0;
      bad_c  = 1'b0;
      case (funct3)
         F3_LB:  data_c = {{24{byte_v[7]}}, byte_v};
         F3_LBU: data_c = {24'd0, byte_v};
         F3_LH: begin
            data_c = {{16{half_v[15]}}, half_v};
            bad_c  = addr_lo[0];
         end
         F3_LHU: begin
            data_c = {16'd0, half_v};
            bad_c  = addr_lo[0];
         end
         F3_LW: begin
            data_c = word;
            bad_c  = (addr_lo != 2'd0);
         end
         default: bad_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: retires ALU/link results directly and parks on loads
// until the data memory answers or the wait times out.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic [1:0]          wb_src,
   input  logic [REG_AW-1:0]   wb_rd,
   input  logic [XLEN-1:0]     wb_alu_result,
   input  logic [XLEN-1:0]     wb_pc_plus4,
   input  logic [F3_W-1:0]     wb_funct3,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic [REG_AW-1:0]   rd_addr,
   output logic [XLEN-1:0]     rd_data,
   output logic                reg_write_enable,
   output logic                load_pending,
   output logic                err
);

   localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   wb_state_t           state, state_next;
   logic [CW-1:0]       cnt, cnt_next;
   logic [REG_AW-1:0]   ld_rd, ld_rd_next;
   logic [F3_W-1:0]     ld_f3, ld_f3_next;
   logic [1:0]          ld_alo, ld_alo_next;
   logic [REG_AW-1:0]   rd_addr_next;
   logic [XLEN-1:0]     rd_data_next;
   logic                we_next;
   logic                err_next;
   wb_src_t             src_c;
   logic [XLEN-1:0]     ext_data_c;
   logic                ext_bad_c;

   assign src_c = wb_src_t'(wb_src);

   load_extract u_load_extract (
      .funct3  (ld_f3),
      .addr_lo (ld_alo),
      .word    (mem_rdata),
      .data_c  (ext_data_c),
      .bad_c   (ext_bad_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         ld_rd            <= '0;
         ld_f3            <= '0;
         ld_alo           <= '0;
         rd_addr          <= '0;
         rd_data          <= '0;
         reg_write_enable <= 1'b0;
         err              <= 1'b0;
         wb_ready         <= 1'b1;
         load_pending     <= 1'b0;
      end else begin
         state            <= state_next;
         cnt              <= cnt_next;
         ld_rd            <= ld_rd_next;
         ld_f3            <= ld_f3_next;
         ld_alo           <= ld_alo_next;
         rd_addr          <= rd_addr_next;
         rd_data          <= rd_data_next;
         reg_write_enable <= we_next;
         err              <= err_next;
         wb_ready         <= (state_next == IDLE);
         load_pending     <= (state_next == WAIT_MEM);
      end
   end

   // Next state, load context and write-port values; x0 transfers complete without a strobe
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      ld_rd_next   = ld_rd;
      ld_f3_next   = ld_f3;
      ld_alo_next  = ld_alo;
      rd_addr_next = rd_addr;
      rd_data_next = rd_data;
      we_next      = 1'b0;
      err_next     = err;
      case (state)
         IDLE: begin
            if (mem_rvalid) err_next = 1'b1;
            if (wb_valid) begin
               case (src_c)
                  SRC_ALU, SRC_PC4: begin
                     if (wb_rd != '0) begin
                        we_next      = 1'b1;
                        rd_addr_next = wb_rd;
                        rd_data_next = (src_c == SRC_ALU) ? wb_alu_result : wb_pc_plus4;
                     end
                  end
                  SRC_LOAD: begin
                     ld_rd_next  = wb_rd;
                     ld_f3_next  = wb_funct3;
                     ld_alo_next = wb_alu_result[1:0];
                     cnt_next    = '0;
                     state_next  = WAIT_MEM;
                  end
                  default: ;
               endcase
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               state_next = IDLE;
               if (ext_bad_c) begin
                  err_next = 1'b1;
               end else if (ld_rd != '0) begin
                  we_next      = 1'b1;
                  rd_addr_next = ld_rd;
                  rd_data_next = ext_data_c;
               end
            end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized retire stream
// checked against a lane-shift reference model of load extraction.
module tb_writeback_unit;
   import wb_pkg::*;

   localparam int unsigned MEM_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [1:0]  wb_src;
   logic [4:0]  wb_rd;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_pc_plus4;
   logic [2:0]  wb_funct3;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        reg_write_enable;
   logic        load_pending;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   writeback_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_src(wb_src),
      .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_pc_plus4(wb_pc_plus4),
      .wb_funct3(wb_funct3), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rd_addr(rd_addr), .rd_data(rd_data), .reg_write_enable(reg_write_enable),
      .load_pending(load_pending), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   // Reference load semantics: {bad, data}, using shifts and arithmetic sign extension
   function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] w);
      logic [31:0] b, h, d;
      logic        bad;
      b = (w >> (8 * addr[1:0])) & 32'hFF;
      h = (w >> (16 * addr[1])) & 32'hFFFF;
      bad = 1'b0;
      d = 32'd0;
      case (f3)
         3'd0: d = (b >= 32'd128) ? b - 32'd256 : b;
         3'd4: d = b;
         3'd1: begin d = (h >= 32'd32768) ? h - 32'd65536 : h; bad = (addr % 2 != 0); end
         3'd5: begin d = h; bad = (addr % 2 != 0); end
         3'd2: begin d = w; bad = (addr % 4 != 0); end
         default: bad = 1'b1;
      endcase
      return {bad, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      wb_valid = 1'b0; wb_src = 2'd0; wb_rd = 5'd0; wb_alu_result = 32'd0;
      wb_pc_plus4 = 32'd0; wb_funct3 = 3'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3);
      wb_valid = 1'b1; wb_src = src; wb_rd = rd; wb_alu_result = alu;
      wb_pc_plus4 = pc4; wb_funct3 = f3;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      step();
      n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      n_checks++; if (reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", reg_write_enable); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", wb_ready); end
      n_checks++; if (load_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", load_pending); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_alu();
      send(SRC_ALU, 5'd5, 32'hDEAD_BEEF, 32'h0, 3'd0);
      step();
      wb_valid = 1'b0;
      n_checks++; if (reg_write_enable !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b expected 1", reg_write_enable); end
      n_checks++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", rd_addr); end
      n_checks++; if (rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alu_data: got %h expected deadbeef", rd_data); end
      step();
      n_checks++; if (reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL alu_single_strobe: got %b expected 0", reg_write_enable); end
   endtask

   task automatic test_load_byte();
      send(SRC_LOAD, 5'd7, 32'h0000_1003, 32'h0, F3_LB);
      step();
      wb_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (wb_ready !== 1'b0 || load_pending !== 1'b1 || reg_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL lb_wait%0d: got ready=%b pending=%b we=%b expected 0 1 0", i, wb_ready, load_pending, reg_write_enable);
         end
         if (i < 3) step();
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF7F;
      step();
      mem_rvalid = 1'b0;
      n_checks++; if (reg_write_enable !== 1'b1 || rd_addr !== 5'd7) begin n_fail++; $display("FAIL lb_write: got we=%b rd=%0d expected 1 7", reg_write_enable, rd_addr); end
      n_checks++; if (rd_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", rd_data); end
      n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready_back: got %b expected 1", wb_ready); end
      step();
      n_checks++; if (reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL lb_single_strobe: got %b expected 0", reg_write_enable); end
   endtask

   task automatic test_load_half();
      logic [2:0]  f3s [2];
      logic [31:0] exp [2];
      f3s[0] = F3_LHU; exp[0] = 32'h0000_8001;
      f3s[1] = F3_LH;  exp[1] = 32'hFFFF_8001;
      for (int k = 0; k < 2; k++) begin
         send(SRC_LOAD, 5'd6, 32'h0000_2002, 32'h0, f3s[k]);
         step();
         wb_valid = 1'b0;
         mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
         step();
         mem_rvalid = 1'b0;
         n_checks++; if (reg_write_enable !== 1'b1 || rd_data !== exp[k]) begin
            n_fail++; $display("FAIL half_%0d: got we=%b data=%h expected 1 %h", k, reg_write_enable, rd_data, exp[k]);
         end
      end
      step();
   endtask

   task automatic test_back_to_back();
      send(SRC_ALU, 5'd0, 32'h1234_5678, 32'h0, 3'd0);
      step();
      n_checks++; if (reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_x0: got we=%b expected 0", reg_write_enable); end
      send(SRC_PC4, 5'd1, 32'h0, 32'h0000_0104, 3'd0);
      step();
      n_checks++; if (reg_write_enable !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'h104) begin
         n_fail++; $display("FAIL b2b_pc4: got we=%b rd=%0d data=%h expected 1 1 00000104", reg_write_enable, rd_addr, rd_data);
      end
      send(SRC_ALU, 5'd2, 32'hAAAA_0002, 32'h0, 3'd0);
      step();
      n_checks++; if (reg_write_enable !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 32'hAAAA_0002) begin
         n_fail++; $display("FAIL b2b_alu2: got we=%b rd=%0d data=%h expected 1 2 aaaa0002", reg_write_enable, rd_addr, rd_data);
      end
      send(SRC_NONE, 5'd3, 32'hBBBB_0003, 32'h0, 3'd0);
      step();
      wb_valid = 1'b0;
      n_checks++; if (reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_none: got we=%b expected 0", reg_write_enable); end
      step();
   endtask

   task automatic test_misaligned();
      logic [2:0]  f3s  [3];
      logic [31:0] adrs [3];
      f3s[0] = F3_LW; adrs[0] = 32'h0000_3002;
      f3s[1] = F3_LH; adrs[1] = 32'h0000_3001;
      f3s[2] = 3'd3;  adrs[2] = 32'h0000_3000;
      for (int k = 0; k < 3; k++) begin
         do_reset();
         send(SRC_LOAD, 5'd4, adrs[k], 32'h0, f3s[k]);
         step();
         wb_valid = 1'b0;
         step();
         mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
         step();
         mem_rvalid = 1'b0;
         n_checks++; if (reg_write_enable !== 1'b0 || err !== 1'b1 || wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL misaligned_%0d: got we=%b err=%b ready=%b expected 0 1 1", k, reg_write_enable, err, wb_ready);
         end
      end
   endtask

   task automatic test_timeout();
      int   cycles;
      logic saw_we;
      do_reset();
      send(SRC_LOAD, 5'd3, 32'h0000_4000, 32'h0, F3_LW);
      step();
      wb_valid = 1'b0;
      cycles = 0;
      saw_we = 1'b0;
      while (wb_ready !== 1'b1 && cycles < 100) begin
         saw_we |= reg_write_enable;
         step();
         cycles++;
      end
      saw_we |= reg_write_enable;
      n_checks++; if (cycles != MEM_TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", cycles, MEM_TIMEOUT); end
      n_checks++; if (err !== 1'b1 || load_pending !== 1'b0) begin n_fail++; $display("FAIL timeout_err: got err=%b pending=%b expected 1 0", err, load_pending); end
      n_checks++; if (saw_we !== 1'b0) begin n_fail++; $display("FAIL timeout_nowrite: got %b expected 0", saw_we); end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      send(SRC_ALU, 5'd9, 32'h0000_0099, 32'h0, 3'd0);
      step();
      send(SRC_LOAD, 5'd9, 32'h0000_5000, 32'h0, F3_LB);
      step();
      wb_valid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (rd_addr !== 5'd0 || rd_data !== 32'd0 || reg_write_enable !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL midreset_outputs: got rd=%0d data=%h we=%b err=%b expected 0 0 0 0", rd_addr, rd_data, reg_write_enable, err);
      end
      n_checks++; if (wb_ready !== 1'b1 || load_pending !== 1'b0) begin
         n_fail++; $display("FAIL midreset_state: got ready=%b pending=%b expected 1 0", wb_ready, load_pending);
      end
      step();
      rst_n = 1'b1;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
      step();
      mem_rvalid = 1'b0;
      n_checks++; if (reg_write_enable !== 1'b0 || err !== 1'b1) begin
         n_fail++; $display("FAIL midreset_stray: got we=%b err=%b expected 0 1", reg_write_enable, err);
      end
   endtask

   task automatic test_random();
      logic [1:0]  src;
      logic [4:0]  rd;
      logic [31:0] alu, pc4, w;
      logic [2:0]  f3;
      logic [32:0] r;
      logic        exp_we, exp_err;
      logic [31:0] exp_data;
      int          dly;
      do_reset();
      exp_err = 1'b0;
      for (int t = 0; t < 60; t++) begin
         src = 2'($urandom_range(0, 3));
         rd  = 5'($urandom_range(0, 31));
         alu = $urandom;
         pc4 = $urandom;
         f3  = 3'($urandom_range(0, 7));
         send(src, rd, alu, pc4, f3);
         step();
         wb_valid = 1'b0;
         if (src != SRC_LOAD) begin
            exp_we   = (src == SRC_ALU || src == SRC_PC4) && rd != 5'd0;
            exp_data = (src == SRC_ALU) ? alu : pc4;
         end else begin
            dly = $urandom_range(0, 4);
            for (int i = 0; i < dly; i++) begin
               n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_stall: got ready=%b expected 0", t, wb_ready); end
               step();
            end
            w = $urandom;
            mem_rvalid = 1'b1; mem_rdata = w;
            step();
            mem_rvalid = 1'b0;
            r = ref_load(f3, alu, w);
            exp_we   = !r[32] && rd != 5'd0;
            exp_data = r[31:0];
            if (r[32]) exp_err = 1'b1;
         end
         n_checks++; if (reg_write_enable !== exp_we) begin
            n_fail++; $display("FAIL rnd%0d_we: got %b expected %b (src=%0d rd=%0d f3=%0d)", t, reg_write_enable, exp_we, src, rd, f3);
         end
         if (exp_we) begin
            n_checks++; if (rd_addr !== rd || rd_data !== exp_data) begin
               n_fail++; $display("FAIL rnd%0d_data: got rd=%0d data=%h expected %0d %h", t, rd_addr, rd_data, rd, exp_data);
            end
         end
         n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", t, err, exp_err); end
      end
      drive_idle();
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_byte();
      test_load_half();
      test_back_to_back();
      test_misaligned();
      test_timeout();
      test_reset_mid_load();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
